// File: rtl/ps2_rx_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | ps2_rx_fifo : filtered PS/2 receiver, E0/F0 prefix decoder and FWFT FIFO    |
// | Revision    : 1.0                                                           |
// +-----------------------------------------------------------------------------+
module ps2_rx_fifo #(
    parameter int FILT_LEN    = 4,
    parameter int TIMEOUT_CYC = 50000,
    parameter int FIFO_DEPTH  = 8,
    parameter int FIFO_AW     = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ps2k_clk,
    input  logic               ps2k_data,
    output logic [7:0]         code_byte,
    output logic               code_ext,
    output logic               code_brk,
    output logic               code_valid,
    input  logic               code_ready,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               err_parity,
    output logic               err_frame,
    output logic               err_timeout,
    output logic               overflow,
    input  logic               clr_overflow
);
    localparam int FCW = $clog2(FILT_LEN + 1);
    localparam int TCW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [FCW-1:0]   FILT_LAST = FCW'(FILT_LEN - 1);
    localparam logic [TCW-1:0]   TO_LAST   = TCW'(TIMEOUT_CYC - 1);
    localparam logic [FIFO_AW:0] DEPTH_CNT = (FIFO_AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic [1:0] clk_sync;
    logic [1:0] data_sync;
    logic [1:0] sync_lvl;
    logic [1:0] filt_lvl;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2k_clk};
            data_sync <= {data_sync[0], ps2k_data};
        end
    end

    assign sync_lvl = {data_sync[1], clk_sync[1]};

    // Bit 0 filters the PS/2 clock, bit 1 the PS/2 data line.
    for (genvar g = 0; g < 2; g++) begin : g_filt
        logic [FCW-1:0] cnt;
        logic           lvl;
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt <= '0;
                lvl <= 1'b1;
            end else if (sync_lvl[g] == lvl) begin
                cnt <= '0;
            end else if (cnt == FILT_LAST) begin
                cnt <= '0;
                lvl <= sync_lvl[g];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
        assign filt_lvl[g] = lvl;
    end

    logic fclk_q;
    logic strobe;
    logic sdata;

    always_ff @(posedge clk) begin
        if (rst) fclk_q <= 1'b1;
        else     fclk_q <= filt_lvl[0];
    end

    assign strobe = fclk_q & ~filt_lvl[0];
    assign sdata  = filt_lvl[1];

    state_t         state, state_nxt;
    logic [2:0]     bit_cnt;
    logic [7:0]     shreg;
    logic           par_bit;
    logic [TCW-1:0] to_cnt;
    logic           to_hit;
    logic           frame_bad, parity_bad, byte_good;
    logic           byte_vld;

    // to_cnt equals the number of cycles elapsed since the last strobe cycle.
    assign to_hit      = (state != S_IDLE) && !strobe && (to_cnt == TO_LAST);
    assign err_timeout = to_hit;

    always_comb begin
        state_nxt  = state;
        frame_bad  = 1'b0;
        parity_bad = 1'b0;
        byte_good  = 1'b0;
        if (to_hit) begin
            state_nxt = S_IDLE;
        end else if (strobe) begin
            case (state)
                S_IDLE:   if (!sdata) state_nxt = S_DATA;
                S_DATA:   if (bit_cnt == 3'd7) state_nxt = S_PARITY;
                S_PARITY: state_nxt = S_STOP;
                S_STOP: begin
                    state_nxt = S_IDLE;
                    if (!sdata)                    frame_bad  = 1'b1;
                    else if (~^{shreg, par_bit})   parity_bad = 1'b1;
                    else                           byte_good  = 1'b1;
                end
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            to_cnt     <= '0;
            err_frame  <= 1'b0;
            err_parity <= 1'b0;
            byte_vld   <= 1'b0;
        end else begin
            state      <= state_nxt;
            err_frame  <= frame_bad;
            err_parity <= parity_bad;
            byte_vld   <= byte_good;
            if (strobe)                to_cnt <= TCW'(1);
            else if (state == S_IDLE)  to_cnt <= '0;
            else                       to_cnt <= to_cnt + 1'b1;
            if (strobe) begin
                case (state)
                    S_IDLE:   bit_cnt <= '0;
                    S_DATA: begin
                        shreg   <= {sdata, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    S_PARITY: par_bit <= sdata;
                    default:  ;
                endcase
            end
        end
    end

    logic ext_flag, brk_flag;
    logic is_e0, is_f0;
    logic push;

    assign is_e0 = (shreg == 8'hE0);
    assign is_f0 = (shreg == 8'hF0);
    assign push  = byte_vld && !is_e0 && !is_f0;

    always_ff @(posedge clk) begin
        if (rst) begin
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
        end else if (err_parity || err_frame || err_timeout) begin
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
        end else if (byte_vld) begin
            if (is_e0) begin
                ext_flag <= 1'b1;
            end else if (is_f0) begin
                brk_flag <= 1'b1;
            end else begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
            end
        end
    end

    logic [9:0]         mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               full, pop, wr_en, drop;

    assign full       = (count == DEPTH_CNT);
    assign code_valid = (count != '0);
    assign pop        = code_valid & code_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign wr_en      = push & (~full | pop);
    assign drop       = push & full & ~pop;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= {ext_flag, brk_flag, shreg};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop)              overflow <= 1'b1;
            else if (clr_overflow) overflow <= 1'b0;
        end
    end

    assign {code_ext, code_brk, code_byte} = code_valid ? mem[rd_ptr] : 10'h000;
    assign fifo_count = count;

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_fifo.sv
`default_nettype none
// tb_ps2_rx_fifo : vector table, corner sequences and random frames against a queue-based model.
module tb_ps2_rx_fifo;
    localparam int FL    = 4;
    localparam int TO    = 100;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int HALF  = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          ps2k_clk, ps2k_data;
    logic [7:0]    code_byte;
    logic          code_ext, code_brk, code_valid, code_ready;
    logic [AW:0]   fifo_count;
    logic          err_parity, err_frame, err_timeout, overflow, clr_overflow;

    always #5 clk = ~clk;

    ps2_rx_fifo #(.FILT_LEN(FL), .TIMEOUT_CYC(TO), .FIFO_DEPTH(DEPTH), .FIFO_AW(AW)) dut (
        .clk(clk), .rst(rst), .ps2k_clk(ps2k_clk), .ps2k_data(ps2k_data),
        .code_byte(code_byte), .code_ext(code_ext), .code_brk(code_brk),
        .code_valid(code_valid), .code_ready(code_ready), .fifo_count(fifo_count),
        .err_parity(err_parity), .err_frame(err_frame), .err_timeout(err_timeout),
        .overflow(overflow), .clr_overflow(clr_overflow)
    );

    typedef struct { int cyc; logic [9:0] ent; } push_ev_t;
    typedef struct { int cyc; logic [2:0] mask; } err_ev_t;
    typedef struct {
        logic [7:0] d;
        logic       bad_par;
        logic       bad_stop;
        logic [2:0] exp_err;
        logic       exp_push;
        logic [9:0] exp_ent;
        int         exp_count;
    } vec_t;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    logic [9:0] mq[$];
    push_ev_t   psched[$];
    err_ev_t    esched[$];
    logic       m_ovf, m_ext, m_brk;
    logic       rnd_mode;
    vec_t       vt[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // One clock: advance the model across the edge, then compare every output.
    task automatic step();
        logic       p_ready, p_clr, p_rst, do_pop, do_push, drop;
        logic [9:0] ent, head, m_head;
        logic [2:0] exp_err;
        p_ready = code_ready;
        p_clr   = clr_overflow;
        p_rst   = rst;
        @(posedge clk);
        #1;
        cyc++;
        ent = '0;
        if (p_rst) begin
            mq.delete(); psched.delete(); esched.delete();
            m_ovf = 1'b0; m_ext = 1'b0; m_brk = 1'b0;
        end else begin
            do_pop  = (mq.size() != 0) && p_ready;
            do_push = 1'b0;
            if (psched.size() != 0 && psched[0].cyc == cyc) begin
                do_push = 1'b1;
                ent = psched[0].ent;
                void'(psched.pop_front());
            end
            drop = do_push && (mq.size() == DEPTH) && !do_pop;
            if (do_pop) void'(mq.pop_front());
            if (do_push && !drop) mq.push_back(ent);
            if (drop) m_ovf = 1'b1;
            else if (p_clr) m_ovf = 1'b0;
        end
        exp_err = 3'b000;
        while (esched.size() != 0 && esched[0].cyc == cyc) begin
            exp_err = exp_err | esched[0].mask;
            void'(esched.pop_front());
        end
        head   = (mq.size() != 0) ? {code_ext, code_brk, code_byte} : 10'h000;
        m_head = (mq.size() != 0) ? mq[0] : 10'h000;
        check("fifo", 32'({code_valid, fifo_count, overflow, head}),
              32'({mq.size() != 0, 4'(mq.size()), m_ovf, m_head}));
        check("err", 32'({err_parity, err_frame, err_timeout}), 32'(exp_err));
        if (rnd_mode) begin
            code_ready   = ($urandom_range(0, 255) < 4);
            clr_overflow = ($urandom_range(0, 63) == 0);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop,
                              input int nbits, input logic glitch, input logic [2:0] exp_err,
                              input logic exp_push, input logic [9:0] exp_ent);
        logic [10:0] bits;
        push_ev_t    pe;
        err_ev_t     ee;
        bits = {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2k_data = bits[i];
            for (int k = 0; k < HALF; k++) begin
                if (glitch && k == 7) ps2k_clk = 1'b0;
                if (glitch && k == 8) ps2k_clk = 1'b1;
                step();
            end
            ps2k_clk = 1'b0;
            if (i == nbits - 1) begin
                if (exp_err != 3'b000) begin
                    ee.cyc  = (nbits == 11) ? cyc + FL + 3 : cyc + FL + TO + 1;
                    ee.mask = exp_err;
                    esched.push_back(ee);
                end
                if (exp_push) begin
                    pe.cyc = cyc + FL + 4;
                    pe.ent = exp_ent;
                    psched.push_back(pe);
                end
            end
            for (int k = 0; k < HALF; k++) begin
                if (glitch && k == 2) ps2k_data = ~bits[i];
                if (glitch && k == 3) ps2k_data = bits[i];
                if (glitch && k == 7) ps2k_clk = 1'b1;
                if (glitch && k == 8) ps2k_clk = 1'b0;
                step();
            end
            ps2k_clk = 1'b1;
        end
        ps2k_data = 1'b1;
    endtask

    // Expected outcome of a complete frame from the protocol rules, tracking prefixes.
    task automatic send_model(input logic [7:0] d, input logic bad_par, input logic bad_stop,
                              input logic glitch);
        logic [2:0] err;
        logic       psh;
        logic [9:0] ent;
        err = 3'b000; psh = 1'b0; ent = '0;
        if (bad_stop)     err = 3'b010;
        else if (bad_par) err = 3'b100;
        if (err != 3'b000) begin
            m_ext = 1'b0; m_brk = 1'b0;
        end else if (d == 8'hE0) begin
            m_ext = 1'b1;
        end else if (d == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            psh = 1'b1;
            ent = {m_ext, m_brk, d};
            m_ext = 1'b0; m_brk = 1'b0;
        end
        send_frame(d, bad_par, bad_stop, 11, glitch, err, psh, ent);
    endtask

    initial begin
        vt[0]  = '{8'hF0, 1'b0, 1'b0, 3'b000, 1'b0, 10'h000, 0};
        vt[1]  = '{8'h1C, 1'b0, 1'b0, 3'b000, 1'b1, 10'h11C, 1};
        vt[2]  = '{8'hE0, 1'b0, 1'b0, 3'b000, 1'b0, 10'h000, 1};
        vt[3]  = '{8'hF0, 1'b0, 1'b0, 3'b000, 1'b0, 10'h000, 1};
        vt[4]  = '{8'h75, 1'b0, 1'b0, 3'b000, 1'b1, 10'h375, 2};
        vt[5]  = '{8'h1B, 1'b1, 1'b0, 3'b100, 1'b0, 10'h000, 2};
        vt[6]  = '{8'hE0, 1'b0, 1'b0, 3'b000, 1'b0, 10'h000, 2};
        vt[7]  = '{8'h1B, 1'b0, 1'b1, 3'b010, 1'b0, 10'h000, 2};
        vt[8]  = '{8'h42, 1'b0, 1'b0, 3'b000, 1'b1, 10'h042, 3};
        vt[9]  = '{8'hE0, 1'b0, 1'b0, 3'b000, 1'b0, 10'h000, 3};
        vt[10] = '{8'hE0, 1'b0, 1'b0, 3'b000, 1'b0, 10'h000, 3};
        vt[11] = '{8'h74, 1'b0, 1'b0, 3'b000, 1'b1, 10'h274, 4};
        vt[12] = '{8'hF0, 1'b1, 1'b1, 3'b010, 1'b0, 10'h000, 4};
        vt[13] = '{8'h12, 1'b0, 1'b0, 3'b000, 1'b1, 10'h012, 5};

        ps2k_clk = 1'b1; ps2k_data = 1'b1; code_ready = 1'b0; clr_overflow = 1'b0;
        rst = 1'b1; rnd_mode = 1'b0; m_ovf = 1'b0; m_ext = 1'b0; m_brk = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();
        check("reset", 32'({code_valid, fifo_count, overflow, code_ext, code_brk, code_byte,
                            err_parity, err_frame, err_timeout}), 32'h0);
        repeat (20) step();

        // Single code consumed at once: valid for exactly one cycle.
        code_ready = 1'b1;
        send_model(8'h1C, 1'b0, 1'b0, 1'b0);
        repeat (20) step();

        // Vector table with the consumer stalled, then drain in order.
        code_ready = 1'b0;
        for (int i = 0; i < 14; i++) begin
            send_frame(vt[i].d, vt[i].bad_par, vt[i].bad_stop, 11, 1'b0,
                       vt[i].exp_err, vt[i].exp_push, vt[i].exp_ent);
            repeat (5) step();
            check($sformatf("vec%0d_count", i), 32'(fifo_count), 32'(vt[i].exp_count));
        end
        m_ext = 1'b0; m_brk = 1'b0;
        code_ready = 1'b1;
        repeat (12) step();
        check("drain_count", 32'(fifo_count), 32'd0);

        // Start plus four data bits, then silence.
        send_frame(8'h55, 1'b0, 1'b0, 5, 1'b0, 3'b001, 1'b0, 10'h000);
        repeat (TO + 20) step();
        send_model(8'h42, 1'b0, 1'b0, 1'b0);
        repeat (10) step();

        // Overflow with the consumer stalled.
        code_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            send_model(8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
        end
        repeat (5) step();
        check("ovf_count", 32'(fifo_count), 32'(DEPTH));
        check("ovf_flag", 32'(overflow), 32'd1);
        code_ready = 1'b1;
        repeat (12) step();
        code_ready = 1'b0;
        clr_overflow = 1'b1;
        step();
        clr_overflow = 1'b0;
        step();
        check("ovf_clr", 32'(overflow), 32'd0);

        // Short glitches on both pins during a frame.
        send_model(8'hE0, 1'b0, 1'b0, 1'b1);
        send_model(8'h3A, 1'b0, 1'b0, 1'b1);
        repeat (5) step();
        check("glitch_count", 32'(fifo_count), 32'd1);
        code_ready = 1'b1;
        repeat (5) step();

        // Reset in the middle of a frame with the FIFO holding an entry.
        code_ready = 1'b0;
        send_model(8'h21, 1'b0, 1'b0, 1'b0);
        send_frame(8'h33, 1'b0, 1'b0, 4, 1'b0, 3'b000, 1'b0, 10'h000);
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();
        check("rst_mid", 32'({code_valid, fifo_count, overflow, code_ext, code_brk, code_byte,
                              err_parity, err_frame, err_timeout}), 32'h0);
        repeat (10) step();
        send_model(8'h42, 1'b0, 1'b0, 1'b0);
        repeat (5) step();
        check("rst_next", 32'({fifo_count, code_ext, code_brk, code_byte}), 32'({4'd1, 10'h042}));
        code_ready = 1'b1;
        repeat (5) step();

        // Random frames, prefixes, faults, glitches, stalls and overflow clears.
        rnd_mode = 1'b1;
        for (int i = 0; i < 40; i++) begin
            int         r;
            logic [7:0] d;
            r = int'($urandom_range(0, 9));
            d = (r < 2) ? 8'hE0 : (r < 4) ? 8'hF0 : 8'($urandom);
            send_model(d, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                       $urandom_range(0, 3) == 0);
            repeat ($urandom_range(1, 20)) step();
        end
        rnd_mode = 1'b0;
        code_ready = 1'b1;
        clr_overflow = 1'b0;
        repeat (20) step();
        check("events_done", 32'(psched.size() + esched.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
Parametrised PS/2 device-to-host receiver, successor to the single-byte keyboard driver. Adds a configurable glitch filter, odd-parity and stop-bit checking, and an inter-bit timeout watchdog. Decodes E0 (extended) and F0 (break) prefixes and queues complete scan codes in a first-word-fall-through FIFO with a valid/ready handshake. It sits between the PS/2 pins and game-control logic so that no key event is lost while the consumer is busy.

Parameters:
FILT_LEN, 4, consecutive equal samples required before the filtered ps2k_clk/ps2k_data level changes (>=1)
TIMEOUT_CYC, 50000, clk cycles allowed between strobes inside a frame (1 ms at 50 MHz)
FIFO_DEPTH, 8, FIFO entries, power of 2, >=2
FIFO_AW, 3, log2(FIFO_DEPTH)

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  synchronous active-high reset
ps2k_clk  in  1  PS/2 clock pin, asynchronous
ps2k_data  in  1  PS/2 data pin, asynchronous
code_byte  out  8  head-of-FIFO scan code
code_ext  out  1  head entry was preceded by E0
code_brk  out  1  head entry was preceded by F0 (key release)
code_valid  out  1  FIFO not empty
code_ready  in  1  consumer accepts head entry
fifo_count  out  FIFO_AW+1  number of entries held
err_parity  out  1  1-cycle pulse, parity mismatch
err_frame  out  1  1-cycle pulse, stop bit = 0
err_timeout  out  1  1-cycle pulse, frame abandoned
overflow  out  1  sticky: a code was dropped because the FIFO was full
clr_overflow  in  1  clears overflow

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE, bit counter 0, ext/brk prefix flags 0, FIFO empty. Outputs: code_valid=0, code_byte=0, code_ext=0, code_brk=0, fifo_count=0, all err pulses 0, overflow=0. Filtered clk/data levels = 1. Reset mid-frame aborts the frame with no error pulse.
- Input conditioning: 2-flop synchroniser on each pin, then a counter filter. The filtered level changes only after FILT_LEN consecutive samples differ from the current filtered level.
- Strobe: one-cycle pulse on a filtered-clk 1->0 transition. Data is sampled from the filtered data level in the same cycle.
- Frame FSM, advanced only on strobes:
  - IDLE: sampled 0 -> DATA, cnt=0. Sampled 1 -> stay in IDLE, no error.
  - DATA: shift in LSB first, cnt++. After the 8th bit -> PARITY.
  - PARITY: store bit -> STOP.
  - STOP: go to IDLE. If the stop bit is 0: err_frame pulse, byte discarded. Else if data^parity has even ones: err_parity pulse, byte discarded. Else the byte is delivered to the decoder. When both faults are present, err_frame wins.
- Timeout: counter cleared on every strobe and held at 0 in IDLE. Reaching TIMEOUT_CYC-1 outside IDLE forces IDLE and emits an err_timeout pulse.
- Any err pulse also clears the ext/brk flags.
- Decoder, one cycle after the stop strobe:
  - E0: set ext, no push.
  - F0: set brk, no push.
  - Any other byte: push {ext,brk,byte} and clear both flags.
  - A repeated prefix keeps its flag set.
- FIFO write occurs one cycle after the stop strobe. code_valid rises on the following cycle, i.e. 2 clk cycles after the stop strobe. Outputs show the head entry combinationally from registered storage.
- Pop happens when code_valid & code_ready. code_ready while empty is ignored.
- Push while full: entry dropped, overflow set. Push and pop in the same cycle while full: both succeed and count is unchanged. Push and pop while empty: push only.
- Pointers wrap modulo FIFO_DEPTH. fifo_count = FIFO_DEPTH when full.
- overflow: clr_overflow clears it. If clr_overflow and a new drop occur in the same cycle, overflow stays set.
- Pins that never toggle leave all outputs at their reset values.

Test Plan:
- Send frame 0x1C with correct parity (0), stop 1, code_ready=1 -> code_valid pulses 1 cycle with code_byte=0x1C, ext=0, brk=0, starting 2 cycles after the stop strobe.
- Send F0 then 1C, then E0 F0 75, with code_ready=0 -> fifo_count=2; entries are {0,1,0x1C} and {1,1,0x75}, popped in order.
- Send 0x1B with wrong parity -> err_parity pulse, no push. Send 0x1B with stop=0 -> err_frame pulse, no push. A following E0 prefix is not carried into the next code.
- Send start plus 4 data bits then go silent -> err_timeout exactly TIMEOUT_CYC-1 cycles after the last strobe. The next full frame 0x42 is received correctly.
- With code_ready=0, send FIFO_DEPTH+1 codes -> fifo_count=FIFO_DEPTH and overflow=1. Then raise code_ready -> the first FIFO_DEPTH codes drain in order. clr_overflow clears the flag.
- Inject 1-sample-long glitches (< FILT_LEN) on ps2k_clk during a frame -> no extra strobes, code decoded correctly. Assert rst mid-frame -> all outputs 0, no err pulse, next frame OK.
